// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for a pipeline MEM stage.
// Requests are accepted only in IDLE, the response appears LATENCY+1 cycles after
// the acceptance cycle and is held until the pipeline consumes it.
// Optional feature macro: DMEM_ERR_EN -- misaligned or out-of-range addresses fault
// (rsp_err=1, rsp_rdata=0, no write). Without it rsp_err is 0, the low address bits
// are ignored and the word index wraps modulo DEPTH.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    // WAIT counts down from LATENCY-1 to 0; unused when LATENCY is 0.
    localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic        accept;
    logic        req_fault;
    logic [AW-1:0] idx;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem [DEPTH];

    assign accept = req_valid && req_ready;
    // Taking exactly AW index bits makes out-of-range addresses wrap modulo DEPTH.
    assign idx    = req_addr[AW+1:2];

`ifdef DMEM_ERR_EN
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
`else
    assign req_fault = 1'b0;
    // Address bits outside the word index carry no meaning in this build.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // State register; reset forces IDLE immediately, dropping any pending response.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; ready only in IDLE, valid only in RESP.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latency counter: loaded on acceptance, decremented while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 3'd0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Response register: snapshot of load data / fault taken at the acceptance edge,
    // so later stores cannot disturb a pending load response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_err_q   <= req_fault;
            rsp_rdata_q <= (req_we || req_fault) ? 32'd0 : mem[idx];
        end
    end

    // Byte-lane store into the memory array at the acceptance edge.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; stored data survives reset_n and maps to plain RAM.
        if (accept && req_we && !req_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit memory words (power of two, 16..65536).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the wait cycles between request acceptance and response (0..7).
REQ-003 Port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  meaning the pipeline MEM stage is presenting a request.
REQ-006 Port req_ready  output  1  meaning the responder accepts a request this cycle.
REQ-007 Port req_we  input  1  meaning 1 = store, 0 = load.
REQ-008 Port req_addr  input  32  meaning the byte address.
REQ-009 Port req_wdata  input  32  meaning the store data.
REQ-010 Port req_be  input  4  meaning the store byte enables, bit i = byte lane i.
REQ-011 Port rsp_valid  output  1  meaning a response is presented.
REQ-012 Port rsp_ready  input  1  meaning the pipeline consumes the response.
REQ-013 Port rsp_rdata  output  32  meaning the load data; 0 for stores.
REQ-014 Port rsp_err  output  1  meaning the access faulted (see Configuration).

Function
REQ-015 Request handshake SHALL be: transfer when req_valid && req_ready at a rising edge; response transfer when rsp_valid && rsp_ready.
REQ-016 FSM states SHALL be IDLE, WAIT, RESP, with at most one transaction outstanding.
REQ-017 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-018 IDLE->WAIT on acceptance when LATENCY>0; IDLE->RESP on acceptance when LATENCY=0.
REQ-019 WAIT SHALL load a counter with LATENCY-1 on entry and go to RESP when the counter reaches 0, giving rsp_valid exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 RESP->IDLE on the response handshake; otherwise RESP SHALL hold with rsp_rdata/rsp_err stable.
REQ-021 The word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-022 A store SHALL write only the lanes enabled by req_be, at the acceptance edge; req_be=0 SHALL write nothing but still produce a response.
REQ-023 A load SHALL capture the word at the acceptance edge into the response register; a later store cannot change it.
REQ-024 A store response SHALL have rsp_rdata=0.
REQ-025 A response SHALL be able to complete and a new request be accepted no sooner than the cycle after IDLE re-entry (no same-cycle overlap).

Reset
REQ-026 reset_n low SHALL immediately force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready SHALL be 1 after reset_n deasserts.
REQ-027 Reset during WAIT or RESP SHALL drop the response; a store accepted before reset SHALL remain written.
REQ-028 Memory contents SHALL NOT be reset.

Configuration
REQ-029 Macro DMEM_ERR_EN defined: a request with req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH SHALL set rsp_err=1, rsp_rdata=0, suppress any write, and keep normal timing.
REQ-030 Macro DMEM_ERR_EN undefined: rsp_err SHALL be constant 0, req_addr[1:0] ignored, and the index SHALL wrap modulo DEPTH.

Verification
REQ-031 Store 0xDEADBEEF to 0x10, be=0xF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after each accept (LATENCY=2).
REQ-032 Store 0x000000AA to 0x10, be=0x1, over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, data stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-034 LATENCY=0, back-to-back loads -> rsp_valid the cycle after each accept; one accept per 2 cycles maximum.
REQ-035 Pull reset_n low in WAIT after accepting a store of 0x12345678 to 0x20 -> rsp_valid never rises; a subsequent load of 0x20 returns 0x12345678.
REQ-036 With DMEM_ERR_EN, store to 0x22 and load from DEPTH*4 -> rsp_err=1, rsp_rdata=0, memory unchanged; without it, a load from DEPTH*4 returns word 0.
